filter_decimator: RTL

- Sits directly downstream of the 19-bit two-tap averaging filter and consumes its data_out stream.
- Decimates by 2^LOG2_DECIM using block averaging: sums each group of samples and arithmetic-shifts the sum.
- Buffers decimated results in a small FIFO and hands them to the next consumer over a valid/ready handshake.
- Reports buffer occupancy and a sticky overflow flag.

---
 rtl/filter_decimator_if.sv | 34 +++
 rtl/filter_decimator.sv | 114 +++++++++++
 2 files changed

// File: rtl/filter_decimator_if.sv
// Sample-in / decimated-result-out bundle for filter_decimator.
// The slave modport is the decimator; the master modport is the surrounding producer/consumer.
interface filter_decimator_if #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
);
    logic                       in_valid;
    logic signed [WIDTH-1:0]    data_in;
    logic signed [WIDTH-1:0]    out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [$clog2(DEPTH):0]     fill_count;
    logic                       overflow;

    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output out_data,
        output out_valid,
        output fill_count,
        output overflow
    );

    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  fill_count,
        input  overflow
    );
endinterface

// File: rtl/filter_decimator.sv
// Block-averaging decimator (2^LOG2_DECIM samples per result) feeding a show-ahead FIFO
// with a sticky overflow flag; upstream is never back-pressured.
module filter_decimator #(
    parameter int WIDTH      = 19,
    parameter int LOG2_DECIM = 2,
    parameter int DEPTH      = 8
) (
    input  logic               clk,
    input  logic               rst,
    filter_decimator_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             push_valid;
    logic [WIDTH-1:0] push_data;

    generate
        if (LOG2_DECIM == 0) begin : g_pass
            assign push_valid = bus.in_valid;
            assign push_data  = bus.data_in;
        end else begin : g_avg
            localparam int ACC_W = WIDTH + LOG2_DECIM;
            localparam logic [LOG2_DECIM-1:0] LAST_PHASE = '1;

            logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
            logic [LOG2_DECIM-1:0]    phase_q, phase_d;
            logic                     block_done;

            always_comb begin
                // Sign-extending into LOG2_DECIM guard bits keeps the block sum exact.
                acc_sum    = acc_q + {{LOG2_DECIM{bus.data_in[WIDTH-1]}}, bus.data_in};
                block_done = bus.in_valid && (phase_q == LAST_PHASE);
                acc_d      = acc_q;
                phase_d    = phase_q;
                if (bus.in_valid) begin
                    if (phase_q == LAST_PHASE) begin
                        acc_d   = '0;
                        phase_d = '0;
                    end else begin
                        acc_d   = acc_sum;
                        phase_d = phase_q + LOG2_DECIM'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q   <= '0;
                    phase_q <= '0;
                end else begin
                    acc_q   <= acc_d;
                    phase_q <= phase_d;
                end
            end

            // Arithmetic shift floors; the average always fits back into WIDTH bits.
            assign push_valid = block_done;
            assign push_data  = WIDTH'(acc_sum >>> LOG2_DECIM);
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, pop, wr_en;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_W'(DEPTH));
        pop   = !empty && bus.out_ready;
        // A pop on the same edge frees a slot, so a full FIFO can still accept the push.
        wr_en = push_valid && (!full || pop);

        wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q || (push_valid && full && !pop);

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign bus.out_valid  = !empty;
    assign bus.out_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.fill_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule
